// File: rtl/trail_stack.sv
// rtl/trail_stack.sv - LIFO assignment trail with conflict-driven unwinding to the last unflipped decision
module trail_stack #(
  parameter int MAX_VARS      = 64,
  parameter int MAX_VARS_BITS = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [MAX_VARS_BITS-1:0] push_var,
  input  logic                     push_val,
  input  logic                     push_is_dec,
  input  logic [MAX_VARS_BITS-1:0] push_dec_idx,
  input  logic                     conflict,
  output logic                     busy,
  output logic                     unassign_valid,
  output logic [MAX_VARS_BITS-1:0] unassign_var,
  output logic                     done_valid,
  output logic [MAX_VARS_BITS-1:0] back_dec_idx,
  output logic [MAX_VARS_BITS-1:0] flip_var,
  output logic                     flip_val,
  output logic                     unsat,
  output logic [MAX_VARS_BITS:0]   depth
);

  localparam logic [MAX_VARS_BITS:0]   DEPTH_FULL = (MAX_VARS_BITS+1)'(MAX_VARS);
  localparam logic [MAX_VARS_BITS:0]   DEPTH_ONE  = (MAX_VARS_BITS+1)'(1);
  localparam logic [MAX_VARS_BITS-1:0] IDX_ONE    = MAX_VARS_BITS'(1);

  typedef enum logic [1:0] {IDLE, POP, UNSAT} state_t;

  state_t state, state_nxt;

  logic [MAX_VARS_BITS-1:0] var_mem  [MAX_VARS];
  logic                     val_mem  [MAX_VARS];
  logic                     dec_mem  [MAX_VARS];
  logic                     flip_mem [MAX_VARS];
  logic [MAX_VARS_BITS-1:0] idx_mem  [MAX_VARS];

  logic [MAX_VARS_BITS-1:0] wr_idx, top_idx;
  logic                     push_fire, do_flip;
  logic [MAX_VARS_BITS:0]   depth_nxt;
  logic                     unassign_valid_nxt, done_valid_nxt, flip_val_nxt, unsat_nxt;
  logic [MAX_VARS_BITS-1:0] unassign_var_nxt, back_dec_idx_nxt, flip_var_nxt;

  assign push_ready = (state == IDLE) && (depth != DEPTH_FULL);
  assign push_fire  = push_valid && push_ready;
  assign wr_idx     = depth[MAX_VARS_BITS-1:0];
  // Wraps to MAX_VARS-1 when full; the depth==0 case never reads through it.
  assign top_idx    = depth[MAX_VARS_BITS-1:0] - IDX_ONE;

  always_comb begin
    state_nxt          = state;
    depth_nxt          = depth;
    do_flip            = 1'b0;
    unassign_valid_nxt = 1'b0;
    done_valid_nxt     = 1'b0;
    unassign_var_nxt   = unassign_var;
    back_dec_idx_nxt   = back_dec_idx;
    flip_var_nxt       = flip_var;
    flip_val_nxt       = flip_val;
    unsat_nxt          = unsat;
    case (state)
      IDLE: begin
        if (push_fire) depth_nxt = depth + DEPTH_ONE;
        if (conflict)  state_nxt = POP;
      end
      POP: begin
        if (depth == '0) begin
          state_nxt = UNSAT;
          unsat_nxt = 1'b1;
        end else if (dec_mem[top_idx] && !flip_mem[top_idx]) begin
          do_flip          = 1'b1;
          done_valid_nxt   = 1'b1;
          back_dec_idx_nxt = idx_mem[top_idx] + IDX_ONE;
          flip_var_nxt     = var_mem[top_idx];
          flip_val_nxt     = ~val_mem[top_idx];
          state_nxt        = IDLE;
        end else begin
          unassign_valid_nxt = 1'b1;
          unassign_var_nxt   = var_mem[top_idx];
          depth_nxt          = depth - DEPTH_ONE;
        end
      end
      default: state_nxt = UNSAT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      depth          <= '0;
      busy           <= 1'b0;
      unassign_valid <= 1'b0;
      unassign_var   <= '0;
      done_valid     <= 1'b0;
      back_dec_idx   <= '0;
      flip_var       <= '0;
      flip_val       <= 1'b0;
      unsat          <= 1'b0;
    end else begin
      depth          <= depth_nxt;
      busy           <= (state_nxt == POP);
      unassign_valid <= unassign_valid_nxt;
      unassign_var   <= unassign_var_nxt;
      done_valid     <= done_valid_nxt;
      back_dec_idx   <= back_dec_idx_nxt;
      flip_var       <= flip_var_nxt;
      flip_val       <= flip_val_nxt;
      unsat          <= unsat_nxt;
    end
  end

  // Trail contents need no reset; depth alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push_fire) begin
      var_mem[wr_idx]  <= push_var;
      val_mem[wr_idx]  <= push_val;
      dec_mem[wr_idx]  <= push_is_dec;
      flip_mem[wr_idx] <= 1'b0;
      idx_mem[wr_idx]  <= push_dec_idx;
    end else if (do_flip) begin
      val_mem[top_idx]  <= ~val_mem[top_idx];
      flip_mem[top_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trail_stack.sv
// tb/tb_trail_stack.sv - scoreboard bench for trail_stack against a queue-based trail model
module tb_trail_stack;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [5:0] push_var = '0;
  logic       push_val = 1'b0;
  logic       push_is_dec = 1'b0;
  logic [5:0] push_dec_idx = '0;
  logic       conflict = 1'b0;
  logic       busy, unassign_valid, done_valid, flip_val, unsat;
  logic [5:0] unassign_var, back_dec_idx, flip_var;
  logic [6:0] depth;

  trail_stack #(.MAX_VARS(64), .MAX_VARS_BITS(6)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_var(push_var), .push_val(push_val), .push_is_dec(push_is_dec),
    .push_dec_idx(push_dec_idx), .conflict(conflict), .busy(busy),
    .unassign_valid(unassign_valid), .unassign_var(unassign_var),
    .done_valid(done_valid), .back_dec_idx(back_dec_idx),
    .flip_var(flip_var), .flip_val(flip_val), .unsat(unsat), .depth(depth)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] v;
    logic       val;
    logic       dec;
    logic       flipped;
    logic [5:0] didx;
  } ent_t;

  localparam int EV_UNASSIGN = 0;
  localparam int EV_DONE     = 1;
  localparam int EV_UNSAT    = 2;

  typedef struct {
    int         kind;
    logic [5:0] v;
    logic [5:0] b;
    logic       fv;
  } ev_t;

  ent_t trail[$];
  ev_t  exp_q[$];
  bit   m_unsat = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  // Unwind rule: pop until the newest unflipped decision, which is flipped in place.
  function automatic int model_conflict();
    ent_t t;
    ev_t  e;
    int   n = 0;
    while (1) begin
      if (trail.size() == 0) begin
        e.kind = EV_UNSAT; e.v = '0; e.b = '0; e.fv = 1'b0;
        exp_q.push_back(e);
        m_unsat = 1'b1;
        return n + 1;
      end
      t = trail.pop_back();
      if (t.dec && !t.flipped) begin
        e.kind = EV_DONE; e.v = t.v; e.b = t.didx + 6'd1; e.fv = ~t.val;
        exp_q.push_back(e);
        t.val = ~t.val;
        t.flipped = 1'b1;
        trail.push_back(t);
        return n + 1;
      end
      e.kind = EV_UNASSIGN; e.v = t.v; e.b = '0; e.fv = 1'b0;
      exp_q.push_back(e);
      n++;
    end
    return n;
  endfunction

  bit unsat_seen = 1'b0;

  function automatic void expect_ev(int kind, int v, int b, int fv);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_output_kind", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (e.kind == kind && kind == EV_UNASSIGN) check("unassign_var", v, int'(e.v));
    if (e.kind == kind && kind == EV_DONE) begin
      check("flip_var", v, int'(e.v));
      check("back_dec_idx", b, int'(e.b));
      check("flip_val", fv, int'(e.fv));
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      unsat_seen = 1'b0;
    end else begin
      if (unassign_valid && done_valid) check("unassign_done_overlap", 1, 0);
      if (unassign_valid) expect_ev(EV_UNASSIGN, int'(unassign_var), 0, 0);
      if (done_valid) expect_ev(EV_DONE, int'(flip_var), int'(back_dec_idx), int'(flip_val));
      if (unsat && !unsat_seen) begin
        unsat_seen = 1'b1;
        expect_ev(EV_UNSAT, 0, 0, 0);
      end
    end
  end

  // Called at #1 after a rising edge with the DUT idle or terminal.
  task automatic do_op(input bit pv, input int v, input bit val, input bit dec,
                       input int didx, input bit conf);
    bit   exp_ready;
    int   nev = 0;
    int   cyc = 0;
    ent_t t;
    exp_ready = !m_unsat && (trail.size() < 64);
    check("push_ready", int'(push_ready), int'(exp_ready));
    push_valid = pv; push_var = 6'(v); push_val = val; push_is_dec = dec;
    push_dec_idx = 6'(didx); conflict = conf;
    if (pv && exp_ready) begin
      t.v = 6'(v); t.val = val; t.dec = dec; t.flipped = 1'b0; t.didx = 6'(didx);
      trail.push_back(t);
    end
    if (conf && !m_unsat) nev = model_conflict();
    @(posedge clock); #1;
    push_valid = 1'b0; conflict = 1'b0;
    while (busy && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (conf) check("conflict_latency", cyc, nev);
    @(negedge clock); @(posedge clock); #1;
    check("depth", int'(depth), trail.size());
    check("pending_events", exp_q.size(), 0);
    check("unsat", int'(unsat), int'(m_unsat));
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    trail.delete(); exp_q.delete(); m_unsat = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check("reset_depth", int'(depth), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_unsat", int'(unsat), 0);
    check("reset_push_ready", int'(push_ready), 1);
  endtask

  initial begin
    int r;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_unsat", int'(unsat), 0);
    check("rst_done_valid", int'(done_valid), 0);
    check("rst_unassign_valid", int'(unassign_valid), 0);
    check("rst_outputs", int'({back_dec_idx, flip_var, flip_val, unassign_var}), 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Two decisions plus an implication, then two conflicts in a row.
    do_op(1, 3, 1, 1, 0, 0);
    do_op(1, 7, 0, 1, 1, 0);
    do_op(1, 9, 1, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 1);
    check("tp1_depth", int'(depth), 2);
    check("tp1_back_dec_idx", int'(back_dec_idx), 2);
    do_op(0, 0, 0, 0, 0, 1);
    check("tp2_depth", int'(depth), 1);
    check("tp2_flip_val", int'(flip_val), 0);

    // Only flipped decisions and implications left: unwind to UNSAT.
    reset_dut();
    do_op(1, 1, 0, 1, 4, 1);
    do_op(1, 2, 1, 0, 0, 0);
    do_op(1, 4, 1, 1, 5, 1);
    check("tp3_depth", int'(depth), 3);
    do_op(0, 0, 0, 0, 0, 1);
    check("tp3_unsat", int'(unsat), 1);
    do_op(1, 8, 1, 1, 0, 1);
    check("tp3_push_ready", int'(push_ready), 0);

    // Fill to capacity, overflow push, conflict from full.
    reset_dut();
    for (int i = 0; i < 64; i++) do_op(1, i, i[0], (i == 0), 63, 0);
    check("full_push_ready", int'(push_ready), 0);
    check("full_depth", int'(depth), 64);
    do_op(1, 5, 1, 1, 0, 0);
    do_op(0, 0, 0, 0, 0, 1);
    check("full_back_dec_idx_wrap", int'(back_dec_idx), 0);

    // Same-cycle push and conflict.
    reset_dut();
    do_op(1, 12, 1, 1, 2, 0);
    do_op(1, 5, 0, 0, 0, 1);

    // Asynchronous reset in the middle of an unwind.
    reset_dut();
    do_op(1, 1, 1, 1, 0, 0);
    for (int i = 2; i < 7; i++) do_op(1, i, 1, 0, 0, 0);
    conflict = 1'b1;
    void'(model_conflict());
    @(posedge clock); #1 conflict = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_depth", int'(depth), 0);
    check("async_unassign_valid", int'(unassign_valid), 0);
    check("async_push_ready", int'(push_ready), 1);
    trail.delete(); exp_q.delete(); m_unsat = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("post_abort_depth", int'(depth), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (m_unsat) reset_dut();
      r = $urandom_range(0, 99);
      do_op(r >= 6, $urandom_range(0, 63), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 63), r < 12);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trail_stack.md
Name: trail_stack

Overview:
- Backtrack-side counterpart of the decider in the DPLL solver core. The decider emits decisions. The Control issues decisions and implications.
- This block records every assignment (decision or implied) in a LIFO trail. On a conflict it unwinds the trail, one entry per cycle, and unassigns each variable it pops.
- It stops at the most recent unflipped decision and reports the backtrack point: the back_dec_idx the Control writes into the decider, plus the flipped assignment.
- If no unflipped decision remains, it reports UNSAT.

Parameters:
- MAX_VARS, 64, maximum number of variables; this is also the trail depth.
- MAX_VARS_BITS, 6, index width, equal to clog2(MAX_VARS).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- push_valid  in  1  Control presents an assignment to record.
- push_ready  out  1  high when state==IDLE and the trail is not full.
- push_var  in  MAX_VARS_BITS  variable index.
- push_val  in  1  assigned value.
- push_is_dec  in  1  1 = decision, 0 = implication.
- push_dec_idx  in  MAX_VARS_BITS  the decider dec_idx_out that produced this decision (ignored for implications).
- conflict  in  1  single-cycle pulse that starts a backtrack.
- busy  out  1  high in POP.
- unassign_valid  out  1  one popped variable this cycle.
- unassign_var  out  MAX_VARS_BITS  variable to clear.
- done_valid  out  1  one-cycle pulse marking that the backtrack point was found.
- back_dec_idx  out  MAX_VARS_BITS  the flipped entry's stored dec_idx + 1.
- flip_var  out  MAX_VARS_BITS  variable of the flipped decision.
- flip_val  out  1  new value, equal to the inverse of the stored value.
- unsat  out  1  sticky; the problem is unsatisfiable.
- depth  out  MAX_VARS_BITS+1  number of valid trail entries.

Behaviour:
- Entry storage: {var, val, is_dec, flipped, dec_idx}.
- Reset (asynchronous, reset==0):
  - State goes to IDLE and depth to 0.
  - unsat, done_valid, unassign_valid and busy go to 0.
  - back_dec_idx, flip_var, flip_val and unassign_var go to 0.
  - Storage contents are don't-care.
- All outputs except push_ready are registered. push_ready is combinational from state and depth.
- Push: on push_valid && push_ready, write the entry at index depth with flipped=0, then depth+1.
- Full: when depth==MAX_VARS, push_ready=0. A push_valid in that case is ignored, with no write and no error.
- States:
  - IDLE: accepts pushes.
  - POP: unwinds the trail.
  - UNSAT: terminal.
- IDLE:
  - conflict=1 moves to POP on the next edge.
  - If push and conflict occur in the same cycle, the push is written first and the unwind includes the new entry.
- POP, evaluated every cycle on the top entry t = depth-1:
  - depth==0: go to UNSAT and set unsat=1. No done_valid is issued.
  - t is a decision with flipped==0:
    - Do not pop. Rewrite t.val to ~t.val and set t.flipped=1.
    - Register done_valid=1, back_dec_idx=t.dec_idx+1 (truncated to MAX_VARS_BITS), flip_var=t.var, flip_val=~t.val.
    - Return to IDLE. unassign_valid=0 this cycle.
  - Otherwise (an implication, or a decision already flipped):
    - Register unassign_valid=1 and unassign_var=t.var, then depth-1.
    - Stay in POP.
- Latency: with k entries above the target decision, unassign_valid pulses on cycles 1..k after conflict is sampled. done_valid pulses on cycle k+1.
- done_valid and unassign_valid are never high in the same cycle.
- conflict during POP or UNSAT is ignored.
- push_valid during POP or UNSAT is not accepted, because push_ready=0.
- UNSAT: holds unsat=1 and push_ready=0 until reset.
- Reset mid-POP aborts immediately. No further unassign pulses occur and depth reads 0.

Test Plan:
- Push decisions (v3,1,dec0), (v7,0,dec1), then implication v9=1, then pulse conflict -> cycle 1 unassign_var=9; cycle 2 done_valid, back_dec_idx=2, flip_var=7, flip_val=1; depth=2.
- Repeat conflict after the above -> v7 entry is flipped, so it is popped (unassign 7). Then flip v3: back_dec_idx=1, flip_val=0, depth=1.
- Trail holding only flipped decisions and implications (3 entries) plus conflict -> 3 unassign pulses, then unsat=1 on cycle 4 and push_ready stays 0.
- Fill 64 pushes -> push_ready=0 and depth=64. A 65th push_valid leaves depth=64. Conflict then works normally.
- push_valid and conflict in the same cycle with an implication v5 -> v5 is the first unassign_var.
- Assert reset low asynchronously between clock edges during POP -> outputs clear immediately, state is IDLE and depth=0.
